// File: rtl/memory_arbiter_ctrl.sv
// rtl/memory_arbiter_ctrl.sv - two-port round-robin write arbiter with a 16-location sum engine
module memory_arbiter_ctrl #(
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [3:0]       req0_addr,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_addr,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  input  logic             sum_start,
  output logic             sum_busy,
  output logic             sum_done,
  output logic [SUM_W-1:0] sum_result,
  output logic             mem_we,
  output logic [3:0]       mem_waddr,
  output logic [7:0]       mem_wdata,
  output logic [3:0]       mem_raddr1,
  output logic [3:0]       mem_raddr2,
  input  logic [7:0]       mem_rdata1,
  input  logic [7:0]       mem_rdata2
);

  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       k;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] result_q;
  logic             prio1;
  logic             grant0, grant1;
  logic [SUM_W-1:0] acc_sum;

  assign acc_sum    = acc + SUM_W'(mem_rdata1) + SUM_W'(mem_rdata2);
  assign sum_result = reset ? '0 : result_q;

  // Everything is forced low while reset is asserted, even before the state register settles.
  always_comb begin
    state_nxt  = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = 4'd0;
    mem_wdata  = 8'd0;
    mem_raddr1 = 4'd0;
    mem_raddr2 = 4'd0;
    sum_busy   = 1'b0;
    sum_done   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (sum_start) begin
            state_nxt = SUM;
          end else begin
            // prio1 names the requester that wins the next tie
            grant0 = req0_valid && (!req1_valid || !prio1);
            grant1 = req1_valid && !grant0;
          end
        end
        SUM: begin
          sum_busy   = 1'b1;
          mem_raddr1 = {k, 1'b0};
          mem_raddr2 = {k, 1'b1};
          if (k == 3'd7) state_nxt = DONE;
        end
        DONE: begin
          sum_busy  = 1'b1;
          sum_done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      if (grant0) begin
        req0_ready = 1'b1;
        mem_we     = 1'b1;
        mem_waddr  = req0_addr;
        mem_wdata  = req0_data;
      end else if (grant1) begin
        req1_ready = 1'b1;
        mem_we     = 1'b1;
        mem_waddr  = req1_addr;
        mem_wdata  = req1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= 3'd0;
      acc      <= '0;
      result_q <= '0;
      prio1    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0)      prio1 <= 1'b1;
      else if (grant1) prio1 <= 1'b0;
      case (state)
        IDLE: begin
          k   <= 3'd0;
          acc <= '0;
        end
        SUM: begin
          acc <= acc_sum;
          k   <= k + 3'd1;
          if (k == 3'd7) result_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
